// File: rtl/map_check_arbiter_if.sv
// Bundle between the mover FSMs, the shared map_checker and map_check_arbiter.
// slave = arbiter view, master = movers + checker view.
interface map_check_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
);
  // Requester side
  logic [N_REQ-1:0]     req;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ*Y_W-1:0] req_y;
  logic [N_REQ*4-1:0]   req_dir;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     done;
  logic                 rsp_allow;
  logic [X_W-1:0]       rsp_x;
  logic [Y_W-1:0]       rsp_y;

  // Checker side
  logic                 chk_req;
  logic [X_W-1:0]       chk_x;
  logic [Y_W-1:0]       chk_y;
  logic [3:0]           chk_dir;
  logic                 chk_valid;
  logic                 chk_allow;
  logic [X_W-1:0]       chk_nx;
  logic [Y_W-1:0]       chk_ny;

  // Status
  logic                 busy;
  logic                 err_timeout;

  modport slave (
    input  req, req_x, req_y, req_dir,
    input  chk_valid, chk_allow, chk_nx, chk_ny,
    output gnt, done, rsp_allow, rsp_x, rsp_y,
    output chk_req, chk_x, chk_y, chk_dir,
    output busy, err_timeout
  );

  modport master (
    output req, req_x, req_y, req_dir,
    output chk_valid, chk_allow, chk_nx, chk_ny,
    input  gnt, done, rsp_allow, rsp_x, rsp_y,
    input  chk_req, chk_x, chk_y, chk_dir,
    input  busy, err_timeout
  );
endinterface

// File: rtl/map_check_arbiter.sv
// Round-robin sharing of one map_checker among N_REQ movers (req 0 = player).
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module map_check_arbiter #(
  parameter int N_REQ       = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  map_check_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  // Handshakes: req is a level held by the mover until its one-cycle done
  // pulse; chk_req is a level held until chk_valid is seen in WAIT. gnt marks
  // the owner from issue through done; no other slot's inputs are sampled.

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("map_check_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     last_q;
  logic [N_REQ-1:0]     gnt_q;
  logic [N_REQ-1:0]     done_q;
  logic                 rsp_allow_q;
  logic [X_W-1:0]       rsp_x_q;
  logic [Y_W-1:0]       rsp_y_q;
  logic                 chk_req_q;
  logic [X_W-1:0]       chk_x_q;
  logic [Y_W-1:0]       chk_y_q;
  logic [3:0]           chk_dir_q;

  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [N_REQ-1:0]     pick_oh;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [3:0]           sel_dir;

  // Scan from last+N down to last+1 so the smallest offset after last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    for (int i = N_REQ; i >= 1; i--) begin
      int slot;
      slot = (int'(last_q) + i) % N_REQ;
      if (bus.req[slot]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(slot);
      end
    end
  end

  assign pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign sel_x   = bus.req_x[pick_idx*X_W +: X_W];
  assign sel_y   = bus.req_y[pick_idx*Y_W +: Y_W];
  assign sel_dir = bus.req_dir[pick_idx*4 +: 4];

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q;
  logic        err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(N_REQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_allow_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      chk_req_q   <= 1'b0;
      chk_x_q     <= '0;
      chk_y_q     <= '0;
      chk_dir_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gnt_q     <= pick_oh;
            last_q    <= pick_idx;
            chk_x_q   <= sel_x;
            chk_y_q   <= sel_y;
            chk_dir_q <= sel_dir;
            if (sel_dir != 4'd0) begin
              chk_req_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
              cnt_q     <= '0;
`endif
              state_q   <= WAIT;
            end else begin
              // No direction means nothing to check: answer "not allowed" directly.
              rsp_allow_q <= 1'b0;
              rsp_x_q     <= sel_x;
              rsp_y_q     <= sel_y;
              done_q      <= pick_oh;
              state_q     <= RESP;
            end
          end
        end

        WAIT: begin
          if (bus.chk_valid) begin
            chk_req_q   <= 1'b0;
            rsp_allow_q <= bus.chk_allow;
            rsp_x_q     <= bus.chk_allow ? bus.chk_nx : chk_x_q;
            rsp_y_q     <= bus.chk_allow ? bus.chk_ny : chk_y_q;
            done_q      <= gnt_q;
            state_q     <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            chk_req_q   <= 1'b0;
            rsp_allow_q <= 1'b0;
            rsp_x_q     <= chk_x_q;
            rsp_y_q     <= chk_y_q;
            err_q       <= 1'b1;
            done_q      <= gnt_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end

        RESP: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rsp_allow = rsp_allow_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.chk_req   = chk_req_q;
  assign bus.chk_x     = chk_x_q;
  assign bus.chk_y     = chk_y_q;
  assign bus.chk_dir   = chk_dir_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule
